// File: rtl/uart_pkg.sv
// UART definitions shared by the transmit framer and the receive path.
// Holds the parity_type encoding, the transmit FSM state type and the
// parity helpers, so that both directions use the same frame format.
package uart_pkg;

   localparam logic [1:0] NOPARITY00 = 2'b00;
   localparam logic [1:0] ODD        = 2'b01;
   localparam logic [1:0] EVEN       = 2'b10;
   localparam logic [1:0] NOPARITY11 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Both 00 and 11 mean "no parity bit in the frame".
   function automatic logic parity_en(input logic [1:0] ptype);
      return !(ptype == NOPARITY00 || ptype == NOPARITY11);
   endfunction

   // Parity bit that makes the total number of 1s over data+parity
   // even (EVEN) or odd (ODD).
   function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] ptype);
      case (ptype)
         EVEN:    return ^data;
         ODD:     return ~^data;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handshake between an upstream byte source and the UART transmit framer.
// Ports: tx_valid/tx_data/parity_type from the master, tx_ready from the slave.
// A byte moves on a clock edge where tx_valid & tx_ready are both high.
interface uart_tx_framer_if;

   logic       tx_valid;
   logic [7:0] tx_data;
   logic [1:0] parity_type;
   logic       tx_ready;

   modport master (
      output tx_valid,
      output tx_data,
      output parity_type,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      input  parity_type,
      output tx_ready
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while en is high, then wraps.
// Ports: clk, reset_n (sync, active-low), en, tick (high in the terminal-count cycle).
// Latency: tick in the CLKS_PER_BIT-th enabled cycle; dropping en clears the count.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   assign tick = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n || !en) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, STOP_BITS stop bits.
// Ports: clk, reset_n (sync, active-low), bus (byte handshake, slave side), tx, busy, tx_done.
// Latency: start bit on tx one clk after the handshake; tx_ready low for the whole frame.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   uart_tx_framer_if.slave  bus,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_framer: STOP_BITS must be 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
   end

   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_t  state;
   logic [2:0] bit_idx;
   logic       stop_cnt;
   logic [7:0] shadow_dat;
   logic [1:0] shadow_par;
   logic       ready_q;
   logic       tick;
   logic       timer_en;

   // The timer runs only while a frame is in flight, so every state starts
   // from count 0 and the handshake edge leaves it cleared.
   assign timer_en = (state != IDLE);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (timer_en),
      .tick    (tick)
   );

   assign bus.tx_ready = ready_q;

   // Decoded from flops only: high exactly in the last clk of the final stop bit,
   // the same cycle whose closing edge returns the FSM to IDLE.
   assign tx_done = (state == STOP) && (stop_cnt == LAST_STOP) && tick;

   // tx/busy/ready are updated together with the state, so the line always
   // shows the value belonging to the state the FSM is currently in.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         tx         <= 1'b1;
         ready_q    <= 1'b1;
         busy       <= 1'b0;
         bit_idx    <= '0;
         stop_cnt   <= 1'b0;
         shadow_dat <= '0;
         shadow_par <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.tx_valid && ready_q) begin
                  shadow_dat <= bus.tx_data;
                  shadow_par <= bus.parity_type;
                  state      <= START;
                  tx         <= 1'b0;
                  ready_q    <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx      <= shadow_dat[0];
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == 3'd7) begin
                     if (parity_en(shadow_par)) begin
                        state <= PARITY;
                        tx    <= parity_bit(shadow_dat, shadow_par);
                     end else begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        tx       <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shadow_dat[bit_idx + 3'd1];
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state    <= STOP;
                  stop_cnt <= 1'b0;
                  tx       <= 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  if (stop_cnt == LAST_STOP) begin
                     state   <= IDLE;
                     ready_q <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
                  tx <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               ready_q <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
